pc_sequencer: RTL and testbench

- Next-PC controller for the single-cycle RISC-V core. Owns the architectural PC register and decides the next fetch address each cycle: sequential, branch, jump, trap vector, or trap return.
- Drives a req/ack fetch handshake to instruction memory and presents each accepted instruction's PC to decode.
- Detects misaligned targets and holds the EPC and bad-address state for the trap path.

---
 rtl/pc_sequencer_if.sv | 9 +
 rtl/pc_sequencer.sv | 134 +++++++++++++
 tb/tb_pc_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Instruction-fetch handshake between the PC sequencer (master) and instruction memory (slave).
interface pc_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;

  modport master (output imem_req, output imem_addr, input  imem_ack);
  modport slave  (input  imem_req, input  imem_addr, output imem_ack);
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC controller: owns the PC, runs the fetch handshake and the trap/redirect path.
// RVC_ALIGN_EN: when defined, targets only need halfword alignment (bit0 checked).
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.master imem,
  input  logic           stall_in,
  input  logic           branch_taken,
  input  logic [31:0]    branch_target,
  input  logic           jump,
  input  logic [31:0]    jump_target,
  input  logic           trap_req,
  input  logic [31:0]    trap_epc,
  input  logic           mret,
  output logic           fetch_valid,
  output logic [31:0]    fetch_pc,
  output logic           trap_taken,
  output logic [31:0]    epc_out,
  output logic [31:0]    badaddr_out
);
  typedef enum logic [1:0] {BOOT, REQ, STALL, TRAP} state_t;
  // Encoded so that a numerically larger kind has higher priority.
  typedef enum logic [2:0] {RD_NONE, RD_BR, RD_JMP, RD_MRET, RD_TRAP} rd_kind_t;
  typedef struct packed {
    rd_kind_t    kind;
    logic [31:0] tgt;
  } redir_t;

  localparam redir_t REDIR_NONE = '{kind: RD_NONE, tgt: 32'h0};

  state_t      state;
  logic [31:0] pc;
  logic        req_q;
  redir_t      pend, cur, sel;
  logic        commit, to_trap;

  function automatic logic misaligned(input logic [31:0] a);
`ifdef RVC_ALIGN_EN
    return a[0];
`else
    return |a[1:0];
`endif
  endfunction

  always_comb begin
    cur = REDIR_NONE;
    if (trap_req)          cur = '{kind: RD_TRAP, tgt: trap_epc};
    else if (mret)         cur = '{kind: RD_MRET, tgt: epc_out};
    else if (jump)         cur = '{kind: RD_JMP,  tgt: {jump_target[31:1], 1'b0}};
    else if (branch_taken) cur = '{kind: RD_BR,   tgt: branch_target};
  end

  // pend is always empty in STALL, so sel reduces to the live redirect there.
  assign sel     = (cur.kind > pend.kind) ? cur : pend;
  assign commit  = (sel.kind != RD_NONE) &&
                   (((state == REQ) && imem.imem_ack) || (state == STALL));
  assign to_trap = (sel.kind == RD_TRAP) || misaligned(sel.tgt);

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= BOOT;
      pc          <= RESET_VECTOR;
      req_q       <= 1'b0;
      pend        <= REDIR_NONE;
      fetch_valid <= 1'b0;
      fetch_pc    <= 32'h0;
      trap_taken  <= 1'b0;
      epc_out     <= 32'h0;
      badaddr_out <= 32'h0;
    end else begin
      fetch_valid <= 1'b0;
      trap_taken  <= 1'b0;
      case (state)
        BOOT: begin
          state <= REQ;
          req_q <= 1'b1;
        end
        REQ: begin
          if (imem.imem_ack) begin
            pend <= REDIR_NONE;
            if (!commit) begin
              fetch_valid <= 1'b1;
              fetch_pc    <= pc;
              pc          <= pc + 32'd4;
            end
            if (commit && to_trap) begin
              state      <= TRAP;
              trap_taken <= 1'b1;
              req_q      <= 1'b0;
            end else if (stall_in) begin
              state <= STALL;
              req_q <= 1'b0;
            end
          end else if (cur.kind > pend.kind) begin
            pend <= cur;
          end
        end
        STALL: begin
          if (commit && to_trap) begin
            state      <= TRAP;
            trap_taken <= 1'b1;
          end else if (!stall_in) begin
            state <= REQ;
            req_q <= 1'b1;
          end
        end
        TRAP: begin
          pc    <= TRAP_VECTOR;
          state <= REQ;
          req_q <= 1'b1;
        end
        default: state <= BOOT;
      endcase

      // A misaligned target is never loaded; the last accepted PC becomes the EPC.
      if (commit) begin
        if (sel.kind == RD_TRAP) begin
          epc_out <= sel.tgt;
        end else if (misaligned(sel.tgt)) begin
          badaddr_out <= sel.tgt;
          epc_out     <= fetch_pc;
        end else begin
          pc <= sel.tgt;
        end
      end
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: fetch flow, redirects, traps, stalls, reset.
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic        stall_in, branch_taken, jump, trap_req, mret;
  logic [31:0] branch_target, jump_target, trap_epc;
  logic        fetch_valid, trap_taken;
  logic [31:0] fetch_pc, epc_out, badaddr_out;
  int          checks = 0;
  int          failures = 0;

  pc_sequencer_if imem_if();

  pc_sequencer dut (
    .clk(clk), .reset(reset), .imem(imem_if),
    .stall_in(stall_in), .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .trap_req(trap_req), .trap_epc(trap_epc),
    .mret(mret), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .trap_taken(trap_taken), .epc_out(epc_out), .badaddr_out(badaddr_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall_in = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    trap_req = 1'b0; mret = 1'b0; branch_target = '0; jump_target = '0;
    trap_epc = '0; imem_if.imem_ack = 1'b1;
    tick(); tick();
    chk("rst_req", 32'(imem_if.imem_req), 32'd0);
    chk("rst_addr", imem_if.imem_addr, 32'h0);
    chk("rst_fv", 32'(fetch_valid), 32'd0);
    chk("rst_fpc", fetch_pc, 32'h0);
    chk("rst_trap", 32'(trap_taken), 32'd0);
    chk("rst_epc", epc_out, 32'h0);
    chk("rst_bad", badaddr_out, 32'h0);

    // boot cycle, then back-to-back fetches with ack tied high
    reset = 1'b0;
    chk("boot_req", 32'(imem_if.imem_req), 32'd0);
    tick();
    chk("req0_req", 32'(imem_if.imem_req), 32'd1);
    chk("req0_addr", imem_if.imem_addr, 32'h0);
    chk("req0_fv", 32'(fetch_valid), 32'd0);
    tick();
    chk("seq4_addr", imem_if.imem_addr, 32'h4);
    chk("seq4_fv", 32'(fetch_valid), 32'd1);
    chk("seq4_fpc", fetch_pc, 32'h0);
    tick();
    chk("seq8_addr", imem_if.imem_addr, 32'h8);
    chk("seq8_fpc", fetch_pc, 32'h4);

    // ack delayed three cycles at 0x8
    imem_if.imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("wait%0d_req", i), 32'(imem_if.imem_req), 32'd1);
      chk($sformatf("wait%0d_addr", i), imem_if.imem_addr, 32'h8);
      if (i > 0) chk($sformatf("wait%0d_fv", i), 32'(fetch_valid), 32'd0);
      if (i < 2) tick();
    end
    imem_if.imem_ack = 1'b1;
    tick();
    chk("late_fv", 32'(fetch_valid), 32'd1);
    chk("late_fpc", fetch_pc, 32'h8);
    chk("late_addr", imem_if.imem_addr, 32'hC);
    tick();
    chk("seq10_addr", imem_if.imem_addr, 32'h10);

    // jump coincident with ack: instruction discarded, bit0 dropped
    jump = 1'b1; jump_target = 32'h41;
    tick();
    jump = 1'b0;
    chk("jmp_fv", 32'(fetch_valid), 32'd0);
    chk("jmp_addr", imem_if.imem_addr, 32'h40);

    // branch to a halfword-aligned target
    branch_taken = 1'b1; branch_target = 32'h22;
    tick();
    branch_taken = 1'b0;
`ifdef RVC_ALIGN_EN
    chk("br22_trap", 32'(trap_taken), 32'd0);
    chk("br22_addr", imem_if.imem_addr, 32'h22);
    chk("br22_bad", badaddr_out, 32'h0);
`else
    chk("br22_trap", 32'(trap_taken), 32'd1);
    chk("br22_bad", badaddr_out, 32'h22);
    chk("br22_epc", epc_out, 32'hC);
    chk("br22_req", 32'(imem_if.imem_req), 32'd0);
    tick();
    chk("br22_trap_end", 32'(trap_taken), 32'd0);
    chk("br22_vec", imem_if.imem_addr, 32'h100);
`endif

    // trap beats branch during a stall, then mret returns to the EPC
    reset = 1'b1; tick(); reset = 1'b0;
    tick();
    stall_in = 1'b1;
    tick();
    chk("stl_req", 32'(imem_if.imem_req), 32'd0);
    chk("stl_addr", imem_if.imem_addr, 32'h4);
    trap_req = 1'b1; trap_epc = 32'h30; branch_taken = 1'b1; branch_target = 32'h60;
    tick();
    trap_req = 1'b0; branch_taken = 1'b0;
    chk("stl_trap", 32'(trap_taken), 32'd1);
    chk("stl_epc", epc_out, 32'h30);
    chk("stl_hold", imem_if.imem_addr, 32'h4);
    tick();
    chk("stl_vec", imem_if.imem_addr, 32'h100);
    chk("stl_vec_req", 32'(imem_if.imem_req), 32'd1);
    tick();
    chk("vec_fpc", fetch_pc, 32'h100);
    chk("vec_stl_req", 32'(imem_if.imem_req), 32'd0);
    mret = 1'b1;
    tick();
    mret = 1'b0;
    chk("mret_addr", imem_if.imem_addr, 32'h30);
    chk("mret_epc", epc_out, 32'h30);
    tick();
    chk("stl_pc_held", imem_if.imem_addr, 32'h30);
    chk("stl_req_low", 32'(imem_if.imem_req), 32'd0);
    stall_in = 1'b0;
    tick();
    chk("unstl_req", 32'(imem_if.imem_req), 32'd1);
    chk("unstl_addr", imem_if.imem_addr, 32'h30);

    // reset while waiting at 0x50; the late ack lands in BOOT
    jump = 1'b1; jump_target = 32'h50;
    tick();
    jump = 1'b0; imem_if.imem_ack = 1'b0;
    tick();
    chk("w50_addr", imem_if.imem_addr, 32'h50);
    chk("w50_req", 32'(imem_if.imem_req), 32'd1);
    reset = 1'b1; imem_if.imem_ack = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_req", 32'(imem_if.imem_req), 32'd0);
    chk("mrst_addr", imem_if.imem_addr, 32'h0);
    tick();
    chk("mrst_boot_fv", 32'(fetch_valid), 32'd0);
    chk("mrst_addr0", imem_if.imem_addr, 32'h0);
    tick();
    chk("mrst_fv", 32'(fetch_valid), 32'd1);
    chk("mrst_fpc", fetch_pc, 32'h0);
    chk("mrst_addr4", imem_if.imem_addr, 32'h4);

    // pending redirects: higher priority overwrites, lower is ignored
    imem_if.imem_ack = 1'b0;
    branch_taken = 1'b1; branch_target = 32'h90;
    tick();
    branch_taken = 1'b0; jump = 1'b1; jump_target = 32'hA0;
    tick();
    jump = 1'b0; branch_taken = 1'b1; branch_target = 32'hB0;
    tick();
    chk("pend_req", 32'(imem_if.imem_req), 32'd1);
    chk("pend_addr", imem_if.imem_addr, 32'h4);
    branch_taken = 1'b0; imem_if.imem_ack = 1'b1;
    tick();
    chk("pend_fv", 32'(fetch_valid), 32'd0);
    chk("pend_tgt", imem_if.imem_addr, 32'hA0);

    // pending trap committed at ack
    imem_if.imem_ack = 1'b0; trap_req = 1'b1; trap_epc = 32'h44;
    tick();
    trap_req = 1'b0; imem_if.imem_ack = 1'b1;
    tick();
    chk("ptrap_taken", 32'(trap_taken), 32'd1);
    chk("ptrap_epc", epc_out, 32'h44);
    tick();
    chk("ptrap_vec", imem_if.imem_addr, 32'h100);

    // sequential increment wraps to zero
    jump = 1'b1; jump_target = 32'hFFFF_FFFC;
    tick();
    jump = 1'b0;
    chk("wrap_top", imem_if.imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_zero", imem_if.imem_addr, 32'h0);
    chk("wrap_fpc", fetch_pc, 32'hFFFF_FFFC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
